// File: rtl/verify_metadata.sv
// Receive-side metadata checker: strips the second-to-last beat of every packet,
// checks it against the expected IDs and counter, and reports one status pulse per packet.
module verify_metadata #(
  parameter logic [63:0] EXPECTED_FPGA_ID       = 64'h0,
  parameter logic [63:0] EXPECTED_CONNECTION_ID = 64'h0,
  parameter logic [63:0] INITIAL_COUNTER_VALUE  = 64'h0
) (
  input  logic         s_axis_aclk,
  input  logic         s_axis_areset,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic [511:0] s_axis_tdata,
  input  logic [63:0]  s_axis_tkeep,
  input  logic [5:0]   s_axis_tid,
  input  logic         s_axis_tlast,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic [511:0] m_axis_tdata,
  output logic [63:0]  m_axis_tkeep,
  output logic [5:0]   m_axis_tid,
  output logic         m_axis_tlast,
  output logic         stat_valid,
  output logic         stat_no_meta,
  output logic         stat_fpga_err,
  output logic         stat_conn_err,
  output logic         stat_seq_err,
  output logic         stat_pad_err,
  output logic [63:0]  stat_counter,
  output logic [31:0]  err_count
);

  logic         h_valid;
  logic         h_last;
  logic [511:0] h_data;
  logic [63:0]  h_keep;
  logic [5:0]   h_id;
  logic [63:0]  exp_counter;

  logic accept;
  logic o_free;
  logic end_of_pkt;
  logic meta_drop;
  logic h_to_o;
  logic fpga_err;
  logic conn_err;
  logic seq_err;
  logic pad_err;
  logic any_err;

  assign s_axis_tready = !h_valid || !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign o_free        = !m_axis_tvalid || m_axis_tready;
  assign end_of_pkt    = accept && s_axis_tlast;

  // A last beat arriving behind a non-last beat means H holds the metadata word.
  assign meta_drop = end_of_pkt && h_valid && !h_last;

  // A last beat in H leaves on its own; a non-last beat only when its successor is data.
  assign h_to_o = h_valid && o_free && (h_last || (accept && !s_axis_tlast));

  assign fpga_err = h_data[191:128] != EXPECTED_FPGA_ID;
  assign conn_err = h_data[127:64]  != EXPECTED_CONNECTION_ID;
  assign seq_err  = h_data[63:0]    != exp_counter;
  assign pad_err  = (h_data[511:192] != '0) || (h_keep != '1);
  assign any_err  = fpga_err || conn_err || seq_err || pad_err;

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      h_valid       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      stat_valid    <= 1'b0;
      stat_no_meta  <= 1'b0;
      stat_fpga_err <= 1'b0;
      stat_conn_err <= 1'b0;
      stat_seq_err  <= 1'b0;
      stat_pad_err  <= 1'b0;
      stat_counter  <= '0;
      err_count     <= '0;
      exp_counter   <= INITIAL_COUNTER_VALUE;
    end else begin
      if (accept) begin
        h_valid <= 1'b1;
      end else if (h_to_o) begin
        h_valid <= 1'b0;
      end

      if (h_to_o) begin
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      stat_valid <= end_of_pkt;
      if (end_of_pkt) begin
        stat_no_meta  <= !meta_drop;
        stat_fpga_err <= meta_drop && fpga_err;
        stat_conn_err <= meta_drop && conn_err;
        stat_seq_err  <= meta_drop && seq_err;
        stat_pad_err  <= meta_drop && pad_err;
        stat_counter  <= meta_drop ? h_data[63:0] : 64'h0;
      end

      // Resync to the received counter even on mismatch so one gap flags only once.
      if (meta_drop) begin
        exp_counter <= h_data[63:0] + 64'd1;
        if (any_err && (err_count != 32'hFFFF_FFFF)) begin
          err_count <= err_count + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (accept) begin
      h_data <= s_axis_tdata;
      h_keep <= s_axis_tkeep;
      h_id   <= s_axis_tid;
      h_last <= s_axis_tlast;
    end
    if (h_to_o) begin
      m_axis_tdata <= h_data;
      m_axis_tkeep <= h_keep;
      m_axis_tid   <= h_id;
      m_axis_tlast <= h_last;
    end
  end

endmodule

// File: tb/tb_verify_metadata.sv
// Scoreboard bench for verify_metadata: a packet-level reference model queues expected
// output beats and status words; independent monitors compare whatever the DUT presents.
module tb_verify_metadata;

  localparam logic [63:0] EXP_FPGA = 64'h0;
  localparam logic [63:0] EXP_CONN = 64'h0;
  localparam logic [63:0] INIT_CNT = 64'h0;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic [5:0]   id;
    logic         last;
  } beat_t;

  typedef struct {
    logic        no_meta;
    logic        fpga;
    logic        conn;
    logic        seq;
    logic        pad;
    logic [63:0] counter;
    logic [31:0] errs;
  } stat_t;

  logic         s_axis_aclk;
  logic         s_axis_areset;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic [5:0]   s_axis_tid;
  logic         s_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic [5:0]   m_axis_tid;
  logic         m_axis_tlast;
  logic         stat_valid;
  logic         stat_no_meta;
  logic         stat_fpga_err;
  logic         stat_conn_err;
  logic         stat_seq_err;
  logic         stat_pad_err;
  logic [63:0]  stat_counter;
  logic [31:0]  err_count;

  beat_t       exp_beats[$];
  stat_t       exp_stats[$];
  beat_t       cur_pkt[$];
  logic [63:0] model_cnt;
  logic [31:0] model_errs;
  int          checks = 0;
  int          failures = 0;
  bit          rand_ready = 0;
  logic        ready_force = 1'b1;
  int          valid_pct = 100;

  verify_metadata #(
    .EXPECTED_FPGA_ID(EXP_FPGA),
    .EXPECTED_CONNECTION_ID(EXP_CONN),
    .INITIAL_COUNTER_VALUE(INIT_CNT)
  ) dut (
    .s_axis_aclk(s_axis_aclk),
    .s_axis_areset(s_axis_areset),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tid(s_axis_tid),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tid(m_axis_tid),
    .m_axis_tlast(m_axis_tlast),
    .stat_valid(stat_valid),
    .stat_no_meta(stat_no_meta),
    .stat_fpga_err(stat_fpga_err),
    .stat_conn_err(stat_conn_err),
    .stat_seq_err(stat_seq_err),
    .stat_pad_err(stat_pad_err),
    .stat_counter(stat_counter),
    .err_count(err_count)
  );

  initial s_axis_aclk = 1'b0;
  always #5 s_axis_aclk = ~s_axis_aclk;

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge s_axis_aclk);
      #1;
      if (rand_ready) m_axis_tready = 1'($urandom_range(1));
      else m_axis_tready = ready_force;
    end
  end

  function automatic logic [511:0] randWide();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic beat_t mkData(input bit last);
    beat_t b;
    b.data = randWide();
    b.keep = {$urandom(), $urandom()};
    b.id   = 6'($urandom_range(63));
    b.last = last;
    return b;
  endfunction

  function automatic beat_t mkMeta(input logic [63:0] fpga, input logic [63:0] conn,
                                   input logic [63:0] cnt, input bit pad);
    beat_t b;
    b.data = {320'b0, fpga, conn, cnt};
    b.keep = '1;
    b.id   = 6'($urandom_range(63));
    b.last = 1'b0;
    if (pad) begin
      if ($urandom_range(1) == 0) b.data[192 + $urandom_range(319)] = 1'b1;
      else b.keep[$urandom_range(63)] = 1'b0;
    end
    return b;
  endfunction

  // Reference model: a packet loses its second-to-last beat, which is judged as a whole word.
  function automatic void modelPacket();
    stat_t s;
    beat_t m;
    int    n;
    n = cur_pkt.size();
    s.no_meta = 1'b0;
    s.fpga = 1'b0;
    s.conn = 1'b0;
    s.seq = 1'b0;
    s.pad = 1'b0;
    s.counter = 64'h0;
    if (n == 1) begin
      exp_beats.push_back(cur_pkt[0]);
      s.no_meta = 1'b1;
    end else begin
      m = cur_pkt[n-2];
      for (int i = 0; i < n; i++) if (i != n - 2) exp_beats.push_back(cur_pkt[i]);
      s.fpga    = m.data[191:128] != EXP_FPGA;
      s.conn    = m.data[127:64] != EXP_CONN;
      s.seq     = m.data[63:0] != model_cnt;
      s.pad     = (m.data[511:192] != '0) || (m.keep != '1);
      s.counter = m.data[63:0];
      if ((s.fpga || s.conn || s.seq || s.pad) && model_errs != 32'hFFFF_FFFF)
        model_errs = model_errs + 1;
      model_cnt = m.data[63:0] + 64'd1;
    end
    s.errs = model_errs;
    exp_stats.push_back(s);
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    beat_t e;
    checks++;
    if (exp_beats.size() == 0) begin
      failures++;
      $display("[TB] FAIL out_unexpected: got beat data=%h last=%b, required no beat",
               m_axis_tdata[63:0], m_axis_tlast);
    end else begin
      e = exp_beats.pop_front();
      if (m_axis_tdata !== e.data || m_axis_tkeep !== e.keep ||
          m_axis_tid !== e.id || m_axis_tlast !== e.last) begin
        failures++;
        $display("[TB] FAIL out_beat: got data=%h keep=%h id=%h last=%b, required data=%h keep=%h id=%h last=%b",
                 m_axis_tdata[127:0], m_axis_tkeep, m_axis_tid, m_axis_tlast,
                 e.data[127:0], e.keep, e.id, e.last);
      end
    end
  endtask

  task automatic checkStat();
    stat_t e;
    checks++;
    if (exp_stats.size() == 0) begin
      failures++;
      $display("[TB] FAIL stat_unexpected: got stat_valid=1, required 0");
    end else begin
      e = exp_stats.pop_front();
      if (stat_no_meta !== e.no_meta || stat_fpga_err !== e.fpga || stat_conn_err !== e.conn ||
          stat_seq_err !== e.seq || stat_pad_err !== e.pad || stat_counter !== e.counter ||
          err_count !== e.errs) begin
        failures++;
        $display("[TB] FAIL stat_word: got nm=%b f=%b c=%b s=%b p=%b cnt=%h errs=%0d, required nm=%b f=%b c=%b s=%b p=%b cnt=%h errs=%0d",
                 stat_no_meta, stat_fpga_err, stat_conn_err, stat_seq_err, stat_pad_err,
                 stat_counter, err_count, e.no_meta, e.fpga, e.conn, e.seq, e.pad,
                 e.counter, e.errs);
      end
    end
  endtask

  // Monitor: handshakes, stall stability and status pulses, all sampled on the falling edge.
  initial begin
    bit    held;
    beat_t hb;
    held = 0;
    forever begin
      @(negedge s_axis_aclk);
      if (s_axis_areset) begin
        held = 0;
      end else begin
        if (held) begin
          checks++;
          if (!m_axis_tvalid || m_axis_tdata !== hb.data || m_axis_tkeep !== hb.keep ||
              m_axis_tid !== hb.id || m_axis_tlast !== hb.last) begin
            failures++;
            $display("[TB] FAIL stall_hold: got valid=%b data=%h, required valid=1 data=%h",
                     m_axis_tvalid, m_axis_tdata[127:0], hb.data[127:0]);
          end
        end
        if (m_axis_tvalid && m_axis_tready) checkOutput();
        held = m_axis_tvalid && !m_axis_tready;
        hb.data = m_axis_tdata;
        hb.keep = m_axis_tkeep;
        hb.id   = m_axis_tid;
        hb.last = m_axis_tlast;
        if (stat_valid) checkStat();
      end
    end
  end

  // Entered and left just after a rising edge.
  task automatic sendBeat(input beat_t b);
    int tries;
    bit done;
    tries = 0;
    done = 0;
    while (!done) begin
      s_axis_tdata  = b.data;
      s_axis_tkeep  = b.keep;
      s_axis_tid    = b.id;
      s_axis_tlast  = b.last;
      s_axis_tvalid = ($urandom_range(99) < valid_pct);
      @(negedge s_axis_aclk);
      done = s_axis_tvalid && s_axis_tready;
      @(posedge s_axis_aclk);
      #1;
      tries++;
      if (!done && tries > 2000) begin
        checks++;
        failures++;
        $display("[TB] FAIL send_timeout: got no acceptance in %0d cycles, required acceptance", tries);
        done = 1;
      end
    end
  endtask

  task automatic applyStimulus();
    modelPacket();
    foreach (cur_pkt[i]) sendBeat(cur_pkt[i]);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((exp_beats.size() != 0 || exp_stats.size() != 0) && n < 500) begin
      @(posedge s_axis_aclk);
      #1;
      n++;
    end
    checkVal("drain_pending", 64'(exp_beats.size() + exp_stats.size()), 64'd0);
  endtask

  task automatic doReset();
    s_axis_areset = 1'b1;
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge s_axis_aclk);
    #1;
    model_cnt  = INIT_CNT;
    model_errs = 32'd0;
    @(negedge s_axis_aclk);
    checkVal("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkVal("rst_stat_valid", 64'(stat_valid), 64'd0);
    checkVal("rst_s_tready", 64'(s_axis_tready), 64'd1);
    @(posedge s_axis_aclk);
    #1;
    s_axis_areset = 1'b0;
  endtask

  task automatic sendMetaPkt(input int len, input logic [63:0] cnt);
    cur_pkt.delete();
    for (int i = 0; i < len; i++) begin
      if (i == len - 2) cur_pkt.push_back(mkMeta(EXP_FPGA, EXP_CONN, cnt, 0));
      else cur_pkt.push_back(mkData(i == len - 1));
    end
    applyStimulus();
  endtask

  initial begin
    int          len;
    bit          pad;
    logic [63:0] fpga, conn, cnt;

    s_axis_areset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tid    = '0;
    s_axis_tlast  = 1'b0;
    model_cnt     = INIT_CNT;
    model_errs    = 32'd0;
    repeat (3) @(posedge s_axis_aclk);
    #1;
    @(negedge s_axis_aclk);
    checkVal("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkVal("rst_stat_valid", 64'(stat_valid), 64'd0);
    checkVal("rst_flags", 64'({stat_no_meta, stat_fpga_err, stat_conn_err, stat_seq_err, stat_pad_err}), 64'd0);
    checkVal("rst_stat_counter", stat_counter, 64'd0);
    checkVal("rst_err_count", 64'(err_count), 64'd0);
    @(posedge s_axis_aclk);
    #1;
    s_axis_areset = 1'b0;

    $display("[TB] directed: 4-beat, single-beat, bad FPGA_ID");
    sendMetaPkt(4, 64'd0);
    cur_pkt.delete();
    cur_pkt.push_back(mkData(1));
    applyStimulus();
    cur_pkt.delete();
    cur_pkt.push_back(mkMeta(64'h5, EXP_CONN, model_cnt, 0));
    cur_pkt.push_back(mkData(1));
    applyStimulus();
    waitDrain();
    checkVal("fpga_err_count", 64'(err_count), 64'd1);

    $display("[TB] directed: counter sequence 0,1,3,4");
    doReset();
    sendMetaPkt(3, 64'd0);
    sendMetaPkt(2, 64'd1);
    sendMetaPkt(3, 64'd3);
    sendMetaPkt(2, 64'd4);
    waitDrain();
    checkVal("seq_err_count", 64'(err_count), 64'd1);

    $display("[TB] random: 100 packets with random valid/ready");
    rand_ready = 1;
    valid_pct  = 70;
    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(1, 6);
      cur_pkt.delete();
      for (int i = 0; i < len; i++) begin
        if (len > 1 && i == len - 2) begin
          fpga = ($urandom_range(9) == 0) ? (EXP_FPGA ^ (64'd1 << $urandom_range(63))) : EXP_FPGA;
          conn = ($urandom_range(9) == 0) ? (EXP_CONN ^ (64'd1 << $urandom_range(63))) : EXP_CONN;
          cnt  = ($urandom_range(4) == 0) ? (model_cnt + 64'($urandom_range(1, 5))) : model_cnt;
          pad  = ($urandom_range(9) == 0);
          cur_pkt.push_back(mkMeta(fpga, conn, cnt, pad));
        end else begin
          cur_pkt.push_back(mkData(i == len - 1));
        end
      end
      applyStimulus();
    end
    waitDrain();

    $display("[TB] directed: reset mid-packet");
    rand_ready  = 0;
    ready_force = 1'b0;
    valid_pct   = 100;
    sendBeat(mkData(0));
    sendBeat(mkData(0));
    s_axis_tvalid = 1'b0;
    repeat (3) @(posedge s_axis_aclk);
    #1;
    @(negedge s_axis_aclk);
    checkVal("stall_s_tready", 64'(s_axis_tready), 64'd0);
    checkVal("stall_m_tvalid", 64'(m_axis_tvalid), 64'd1);
    @(posedge s_axis_aclk);
    #1;
    doReset();
    ready_force = 1'b1;
    sendMetaPkt(3, INIT_CNT);
    waitDrain();
    checkVal("final_err_count", 64'(err_count), 64'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
